// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART receive capture block.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = ptr_width(DEPTH),
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers are exactly AW bits wide, so wrap is free for power-of-two depths.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: synchronizer, frame FSM and sticky error flags feeding a byte FIFO.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | counting to mid start bit; a high line there is a glitch
//   DATA  | sampling eight data bits LSB-first at mid-bit
//   STOP  | sampling the stop bit; high pushes the byte, low is a framing error
//   BREAK | line held low after a bad stop bit; wait for it to return high
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic                           rx,
    input  logic                           rd,
    output logic [UART_DATA_BITS-1:0]      rdata,
    output logic                           rvalid,
    output logic [cnt_width(FIFO_DEPTH)-1:0] count,
    output logic                           busy,
    output logic                           frame_err,
    output logic                           overrun,
    input  logic                           clr_err
);

    localparam int BW = ptr_width(BIT_CYCLES);
    localparam logic [BW-1:0] HALF_LD = BW'(BIT_CYCLES / 2 - 1);
    localparam logic [BW-1:0] FULL_LD = BW'(BIT_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX = 3'(UART_DATA_BITS - 1);

    logic                      r_sync1;
    logic                      r_rx_s;
    logic                      r_rx_d;
    rx_state_t                 r_state;
    rx_state_t                 w_state_nxt;
    logic [BW-1:0]             r_bcnt;
    logic [BW-1:0]             w_bcnt_nxt;
    logic [2:0]                r_idx;
    logic [2:0]                w_idx_nxt;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [UART_DATA_BITS-1:0] w_shreg_nxt;
    logic                      w_push;
    logic                      w_frame_set;
    logic                      w_full;
    logic                      w_empty;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s && r_rx_d) begin
                    w_state_nxt = START;
                    w_bcnt_nxt  = HALF_LD;
                end
            end
            START: begin
                if (r_bcnt != '0) begin
                    w_bcnt_nxt = r_bcnt - 1'b1;
                end else if (r_rx_s) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DATA;
                    w_bcnt_nxt  = FULL_LD;
                    w_idx_nxt   = '0;
                end
            end
            DATA: begin
                if (r_bcnt != '0) begin
                    w_bcnt_nxt = r_bcnt - 1'b1;
                end else begin
                    w_shreg_nxt[r_idx] = r_rx_s;
                    w_bcnt_nxt         = FULL_LD;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (r_bcnt != '0) begin
                    w_bcnt_nxt = r_bcnt - 1'b1;
                end else if (r_rx_s) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_frame_set = 1'b1;
                    w_state_nxt = BREAK;
                end
            end
            BREAK: begin
                if (r_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A same-cycle pop frees the slot, so only a push into a full FIFO without rd is lost.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (clr_err) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_frame_set) begin
                frame_err <= 1'b1;
            end
            if (w_push && w_full && !rd) begin
                overrun <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_push  (w_push),
        .i_wdata (r_shreg),
        .i_pop   (rd),
        .o_rdata (rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign rvalid = !w_empty;
    assign busy   = (r_state != IDLE);

endmodule
